// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared constants and helpers for the clock generation block
//
// Purpose: default divider/lock constants and small elaboration-time helpers
//          used by clk_gen_lock and clk_divider.
// Ports:   none (package).
package clk_gen_pkg;

    localparam int DIV_OUT_DEF     = 4;
    localparam int OSC_DIV_DEF     = 96;
    localparam int LOCK_CYCLES_DEF = 64;
    localparam int SDIV_DEF        = 2;

    // Number of clkin cycles the output spends high in a P-cycle period.
    function automatic int ceil_half(int p);
        return (p + 1) / 2;
    endfunction

    // Width of a counter that walks 0..p-1.
    function automatic int cnt_w(int p);
        return $clog2(p);
    endfunction

endpackage

// File: rtl/clk_gen_lock_divider.sv
// rtl/clk_gen_lock_divider.sv - enable-gated integer clock divider with registered output
//
// Purpose: divides clk by P; output high for ceil(P/2) cycles, low for the rest.
//          The first enabled edge drives q high with the counter at phase 0, so a
//          divider released mid-stream starts on a full high phase (no runt pulse).
// Ports:
//   clk    in  1  reference clock, rising edge
//   reset  in  1  asynchronous, active-high reset
//   en     in  1  0 holds cnt=0 and q=0; must be the value valid for this edge
//   q      out 1  divided clock, flop-driven
module clk_divider
    import clk_gen_pkg::*;
#(
    parameter int P = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic q
);

    localparam int             CW   = cnt_w(P);
    localparam logic [CW-1:0]  HI   = CW'(ceil_half(P));
    localparam logic [CW-1:0]  LAST = CW'(P - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          running;

    // cnt holds the phase of the value currently on q; the first enabled
    // edge lands on phase 0 rather than advancing past it.
    always_comb begin
        cnt_n = '0;
        if (running && (cnt != LAST)) begin
            cnt_n = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            running <= 1'b0;
            q       <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            running <= 1'b0;
            q       <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            running <= 1'b1;
            q       <= (cnt_n < HI);
        end
    end

endmodule

// File: rtl/clk_gen_lock.sv
// rtl/clk_gen_lock.sv - lock-gated divided clock, free-running slow clock and lock flag
//
// Purpose: models the board PLL/oscillator pair from one reference clock.
//          Optional feature macro: CLKOUTD_EN adds clkoutd = clkin/(DIV_OUT*SDIV).
// Ports:
//   clkin    in  1  reference clock; all logic on its rising edge
//   reset    in  1  asynchronous, active-high reset
//   clkout   out 1  clkin/DIV_OUT, held 0 until lock
//   oscout   out 1  clkin/OSC_DIV, free-running from reset release
//   lock     out 1  set on the LOCK_CYCLES-th edge after release, sticky until reset
//   clkoutd  out 1  clkin/(DIV_OUT*SDIV), only when CLKOUTD_EN is defined
module clk_gen_lock
    import clk_gen_pkg::*;
#(
    parameter int DIV_OUT     = DIV_OUT_DEF,
    parameter int OSC_DIV     = OSC_DIV_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
    parameter int SDIV        = SDIV_DEF
) (
    input  logic clkin,
    input  logic reset,
    output logic clkout,
    output logic oscout,
    output logic lock
`ifdef CLKOUTD_EN
    ,
    output logic clkoutd
`endif
);

    generate
        if (DIV_OUT < 2) begin : g_bad_div_out
            $error("clk_gen_lock: DIV_OUT must be >= 2");
        end
        if (OSC_DIV < 2) begin : g_bad_osc_div
            $error("clk_gen_lock: OSC_DIV must be >= 2");
        end
        if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
            $error("clk_gen_lock: LOCK_CYCLES must be >= 1");
        end
`ifdef CLKOUTD_EN
        if ((SDIV < 2) || ((SDIV % 2) != 0)) begin : g_bad_sdiv
            $error("clk_gen_lock: SDIV must be even and >= 2");
        end
`endif
    endgenerate

    localparam int            LW      = $clog2(LOCK_CYCLES + 1);
    localparam logic [LW-1:0] LC_LAST = LW'(LOCK_CYCLES - 1);

    logic [LW-1:0] lock_cnt;
    logic          lock_set;
    logic          lock_en;

    // lock_set is true on the edge that registers lock; the gated dividers
    // are enabled from that same edge so their first high phase coincides
    // with lock rising.
    always_comb begin
        lock_set = 1'b0;
        if (!lock && (lock_cnt == LC_LAST)) begin
            lock_set = 1'b1;
        end
        lock_en = lock | lock_set;
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_cnt <= '0;
            lock     <= 1'b0;
        end else if (!lock) begin
            lock_cnt <= lock_cnt + 1'b1;
            lock     <= lock_set;
        end
    end

    clk_divider #(.P(OSC_DIV)) u_osc_div (
        .clk   (clkin),
        .reset (reset),
        .en    (1'b1),
        .q     (oscout)
    );

    clk_divider #(.P(DIV_OUT)) u_out_div (
        .clk   (clkin),
        .reset (reset),
        .en    (lock_en),
        .q     (clkout)
    );

`ifdef CLKOUTD_EN
    clk_divider #(.P(DIV_OUT * SDIV)) u_outd_div (
        .clk   (clkin),
        .reset (reset),
        .en    (lock_en),
        .q     (clkoutd)
    );
`endif

endmodule

// File: tb/tb_clk_gen_lock.sv
// tb/tb_clk_gen_lock.sv - scoreboard testbench for clk_gen_lock
module tb_clk_gen_lock;

    localparam int LOCK_N = 64;
    localparam int OSC_N  = 96;

    logic clkin = 1'b0;
    logic reset = 1'b1;
    logic clkout4, oscout4, lock4;
    logic clkout5, oscout5, lock5;
`ifdef CLKOUTD_EN
    logic clkoutd4, clkoutd5;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int   n;
        logic lock;
        logic osc;
        logic clk4;
        logic clk5;
        logic clkd;
    } exp_t;

    exp_t sb_q[$];
    int   edge_n = 0;

    always #5 clkin = ~clkin;

    clk_gen_lock u_dut4 (
        .clkin   (clkin),
        .reset   (reset),
        .clkout  (clkout4),
        .oscout  (oscout4),
        .lock    (lock4)
`ifdef CLKOUTD_EN
        ,
        .clkoutd (clkoutd4)
`endif
    );

    clk_gen_lock #(.DIV_OUT(5)) u_dut5 (
        .clkin   (clkin),
        .reset   (reset),
        .clkout  (clkout5),
        .oscout  (oscout5),
        .lock    (lock5)
`ifdef CLKOUTD_EN
        ,
        .clkoutd (clkoutd5)
`endif
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: expected outputs after edge n counted from reset release.
    function automatic exp_t model(input int n);
        exp_t e;
        e.n    = n;
        e.lock = (n >= LOCK_N);
        e.osc  = (n >= 1) && (((n - 1) % OSC_N) < (OSC_N / 2));
        e.clk4 = (n >= LOCK_N) && (((n - LOCK_N) % 4) < 2);
        e.clk5 = (n >= LOCK_N) && (((n - LOCK_N) % 5) < 3);
        e.clkd = (n >= LOCK_N) && (((n - LOCK_N) % 8) < 4);
        return e;
    endfunction

    always @(posedge clkin) begin
        if (reset) edge_n = 0;
        else       edge_n = edge_n + 1;
        sb_q.push_back(model(edge_n));
    end

    always @(negedge clkin) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_val($sformatf("lock4@%0d", e.n), int'(lock4),   int'(e.lock));
            check_val($sformatf("osc4@%0d",  e.n), int'(oscout4), int'(e.osc));
            check_val($sformatf("clk4@%0d",  e.n), int'(clkout4), int'(e.clk4));
            check_val($sformatf("lock5@%0d", e.n), int'(lock5),   int'(e.lock));
            check_val($sformatf("clk5@%0d",  e.n), int'(clkout5), int'(e.clk5));
`ifdef CLKOUTD_EN
            check_val($sformatf("clkd@%0d",  e.n), int'(clkoutd4), int'(e.clkd));
`endif
        end
    end

    initial begin
        // Reset held for 10 edges; scoreboard expects all zero.
        repeat (10) @(posedge clkin);
        @(negedge clkin);
        #2 reset = 1'b0;

        // Run past lock and several oscout periods, then assert reset between edges.
        repeat (200) @(posedge clkin);
        check_val("pre_rst_lock", int'(lock4), 1);
        #2 reset = 1'b1;
        #1;
        check_val("async_clkout", int'(clkout4), 0);
        check_val("async_oscout", int'(oscout4), 0);
        check_val("async_lock",   int'(lock4),   0);
        check_val("async_clk5",   int'(clkout5), 0);
        // Expectation for edge 200 was taken before the reset hit.
        sb_q.delete();

        repeat (5) @(posedge clkin);
        @(negedge clkin);
        #2 reset = 1'b0;

        // Relock, clkout start and oscout phase after release.
        repeat (300) @(posedge clkin);
        @(negedge clkin);
        #1;
        check_val("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
